// File: rtl/egress_trans_if.sv
// ============================================================================
// Module   : egress_trans_if
// Brief    : AXIS-style TLP stream bundle (sop/eop framing plus tlast) shared
//            by the egress input and output ports.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface egress_trans_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int USER_W = 4
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;
    logic              sop;
    logic              eop;
    logic              tlast;

    modport master (
        output tdata, tkeep, tuser, tvalid, sop, eop, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, sop, eop,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/egress_trans.sv
// ============================================================================
// Module   : egress_trans
// Brief    : PCIe egress translator: byte-swaps big-endian dwords to the IP
//            core's little-endian order through a 2-entry skid buffer, with
//            framing FSM and debug counters. Optional framing checker is
//            enabled by defining EGRESS_FRAME_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module egress_trans #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int USER_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    egress_trans_if.slave    s_axis_tx,
    egress_trans_if.master   m_axis_tx,
    output logic [31:0]      tx_packet_len,
    output logic [31:0]      tx_sop_cnt,
    output logic [31:0]      tx_eop_cnt,
    output logic [31:0]      tx_err_cnt
);

    localparam int         c_DWORDS = DATA_W / 32;
    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BODY = 1'b1;

    // Output register and skid register
    logic [DATA_W-1:0] r_m_data;
    logic [KEEP_W-1:0] r_m_keep;
    logic [USER_W-1:0] r_m_user;
    logic              r_m_sop;
    logic              r_m_eop;
    logic              r_m_valid;

    logic [DATA_W-1:0] r_sk_data;
    logic [KEEP_W-1:0] r_sk_keep;
    logic [USER_W-1:0] r_sk_user;
    logic              r_sk_sop;
    logic              r_sk_eop;
    logic              r_sk_valid;

    logic              r_s_ready;
    logic [0:0]        r_state;
    logic [31:0]       r_beat_cnt;
    logic [31:0]       r_pkt_len;
    logic [31:0]       r_sop_cnt;
    logic [31:0]       r_eop_cnt;

    logic [DATA_W-1:0] w_swap;
    logic              w_in_hs;
    logic              w_drop;
    logic              w_fwd;
    logic              w_out_free;
    logic              w_sk_valid_nxt;
    logic [31:0]       w_beat_nxt;

    generate
        for (genvar gi = 0; gi < c_DWORDS; gi++) begin : g_swap
            assign w_swap[gi*32 +: 32] = {s_axis_tx.tdata[gi*32 +  0 +: 8],
                                          s_axis_tx.tdata[gi*32 +  8 +: 8],
                                          s_axis_tx.tdata[gi*32 + 16 +: 8],
                                          s_axis_tx.tdata[gi*32 + 24 +: 8]};
        end
    endgenerate

    assign w_in_hs    = s_axis_tx.tvalid & r_s_ready;
    assign w_fwd      = w_in_hs & ~w_drop;
    assign w_out_free = ~r_m_valid | m_axis_tx.tready;
    assign w_beat_nxt = s_axis_tx.sop ? 32'd1 : r_beat_cnt + 32'd1;

`ifdef EGRESS_FRAME_CHECK_EN
    logic        w_restart;
    logic [31:0] r_err_cnt;

    // A beat with no sop outside a packet has no header to belong to: drop it.
    assign w_drop    = (r_state == c_S_IDLE) & ~s_axis_tx.sop;
    assign w_restart = (r_state == c_S_BODY) &  s_axis_tx.sop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 32'd0;
        end else if (w_in_hs & (w_drop | w_restart)) begin
            r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    assign tx_err_cnt = r_err_cnt;
`else
    assign w_drop     = 1'b0;
    assign tx_err_cnt = 32'd0;
`endif

    // Skid fills only when the output is held; it always empties on the next pop.
    always_comb begin
        w_sk_valid_nxt = r_sk_valid;
        if (w_out_free) begin
            w_sk_valid_nxt = 1'b0;
        end else if (w_fwd) begin
            w_sk_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data   <= '0;
            r_m_keep   <= '0;
            r_m_user   <= '0;
            r_m_sop    <= 1'b0;
            r_m_eop    <= 1'b0;
            r_m_valid  <= 1'b0;
            r_sk_data  <= '0;
            r_sk_keep  <= '0;
            r_sk_user  <= '0;
            r_sk_sop   <= 1'b0;
            r_sk_eop   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            if (w_out_free) begin
                if (r_sk_valid) begin
                    r_m_data  <= r_sk_data;
                    r_m_keep  <= r_sk_keep;
                    r_m_user  <= r_sk_user;
                    r_m_sop   <= r_sk_sop;
                    r_m_eop   <= r_sk_eop;
                    r_m_valid <= 1'b1;
                end else if (w_fwd) begin
                    r_m_data  <= w_swap;
                    r_m_keep  <= s_axis_tx.tkeep;
                    r_m_user  <= s_axis_tx.tuser;
                    r_m_sop   <= s_axis_tx.sop;
                    r_m_eop   <= s_axis_tx.eop;
                    r_m_valid <= 1'b1;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_fwd) begin
                r_sk_data <= w_swap;
                r_sk_keep <= s_axis_tx.tkeep;
                r_sk_user <= s_axis_tx.tuser;
                r_sk_sop  <= s_axis_tx.sop;
                r_sk_eop  <= s_axis_tx.eop;
            end
            r_sk_valid <= w_sk_valid_nxt;
            r_s_ready  <= ~w_sk_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_beat_cnt <= 32'd0;
            r_pkt_len  <= 32'd0;
            r_sop_cnt  <= 32'd0;
            r_eop_cnt  <= 32'd0;
        end else if (w_in_hs) begin
            r_sop_cnt <= r_sop_cnt + {31'd0, s_axis_tx.sop};
            r_eop_cnt <= r_eop_cnt + {31'd0, s_axis_tx.eop};
            if (!w_drop) begin
                r_beat_cnt <= w_beat_nxt;
                if (s_axis_tx.eop) begin
                    r_pkt_len <= w_beat_nxt;
                    r_state   <= c_S_IDLE;
                end else if (s_axis_tx.sop) begin
                    r_state   <= c_S_BODY;
                end
            end
        end
    end

    assign s_axis_tx.tready = r_s_ready;
    assign m_axis_tx.tdata  = r_m_data;
    assign m_axis_tx.tkeep  = r_m_keep;
    assign m_axis_tx.tuser  = r_m_user;
    assign m_axis_tx.tvalid = r_m_valid;
    assign m_axis_tx.sop    = r_m_sop;
    assign m_axis_tx.eop    = r_m_eop;
    assign m_axis_tx.tlast  = r_m_eop;

    assign tx_packet_len = r_pkt_len;
    assign tx_sop_cnt    = r_sop_cnt;
    assign tx_eop_cnt    = r_eop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_egress_trans.sv
// ============================================================================
// Module   : tb_egress_trans
// Brief    : Scoreboard bench for egress_trans; framing-checker scenarios are
//            included when EGRESS_FRAME_CHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_egress_trans;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int USER_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic [USER_W-1:0] u;
        logic              l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    egress_trans_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) s_if ();
    egress_trans_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) m_if ();

    logic [31:0] tx_packet_len, tx_sop_cnt, tx_eop_cnt, tx_err_cnt;

    egress_trans #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tx     (s_if),
        .m_axis_tx     (m_if),
        .tx_packet_len (tx_packet_len),
        .tx_sop_cnt    (tx_sop_cnt),
        .tx_eop_cnt    (tx_eop_cnt),
        .tx_err_cnt    (tx_err_cnt)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    beat_t exp_b, got_b;
    bit    mdl_drop;
    bit    mdl_body = 1'b0;

    function automatic logic [DATA_W-1:0] swap_model(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < KEEP_W; i++)
            r[i*8 +: 8] = x[((i / 4) * 4 + 3 - (i % 4)) * 8 +: 8];
        return r;
    endfunction

    // Input side of the scoreboard: predicts which accepted beats reach the IP.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mdl_body = 1'b0;
        end else if (s_if.tvalid && s_if.tready) begin
            mdl_drop = 1'b0;
`ifdef EGRESS_FRAME_CHECK_EN
            mdl_drop = !mdl_body && !s_if.sop;
`endif
            if (!mdl_drop) begin
                mdl_body = s_if.eop ? 1'b0 : (s_if.sop ? 1'b1 : mdl_body);
                sb.push_back('{d: swap_model(s_if.tdata), k: s_if.tkeep,
                               u: s_if.tuser, l: s_if.eop});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) begin
            checks++;
            got_b = '{d: m_if.tdata, k: m_if.tkeep, u: m_if.tuser, l: m_if.tlast};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got d=%h k=%h u=%h l=%b, required no beat",
                         got_b.d, got_b.k, got_b.u, got_b.l);
            end else begin
                exp_b = sb.pop_front();
                if (got_b !== exp_b) begin
                    errors++;
                    $display("FAIL out_beat: got d=%h k=%h u=%h l=%b, required d=%h k=%h u=%h l=%b",
                             got_b.d, got_b.k, got_b.u, got_b.l,
                             exp_b.d, exp_b.k, exp_b.u, exp_b.l);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                             input logic [USER_W-1:0] u, input logic sop, input logic eop);
        int n;
        bit hs;
        n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tuser  = u;
        s_if.sop    = sop;
        s_if.eop    = eop;
        s_if.tvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL push_timeout: got tready=0 for %0d cycles, required acceptance", n);
        end
    endtask

    task automatic idle_in();
        s_if.tvalid = 1'b0;
        s_if.sop    = 1'b0;
        s_if.eop    = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats pending, required 0", sb.size());
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tkeep, m_if.tuser} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tready=%b tvalid=%b tlast=%b data=%h, required all 0",
                     s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        checks++;
        if ({tx_packet_len, tx_sop_cnt, tx_eop_cnt, tx_err_cnt} !== 128'd0) begin
            errors++;
            $display("FAIL reset_counters: got len=%0d sop=%0d eop=%0d err=%0d, required 0",
                     tx_packet_len, tx_sop_cnt, tx_eop_cnt, tx_err_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_rise: got %b, required 1", s_if.tready);
        end
    endtask

    task automatic test_basic();
        m_if.tready = 1'b1;
        push_beat(64'h0011_2233_4455_6677, 8'hFF, 4'h1, 1'b1, 1'b0);
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'h3322_1100_7766_5544) begin
            errors++;
            $display("FAIL basic_latency: got valid=%b data=%h, required valid=1 data=3322110077665544",
                     m_if.tvalid, m_if.tdata);
        end
        push_beat(64'h8899_AABB_CCDD_EEFF, 8'hFF, 4'h1, 1'b0, 1'b0);
        push_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 4'h1, 1'b0, 1'b1);
        idle_in();
        wait_drain();
        check_cnt("basic_len", tx_packet_len, 32'd3);
        check_cnt("basic_sop", tx_sop_cnt, 32'd1);
        check_cnt("basic_eop", tx_eop_cnt, 32'd1);
    endtask

    task automatic test_single();
        push_beat(64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 4'hA, 1'b1, 1'b1);
        idle_in();
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tlast !== 1'b1 || m_if.tkeep !== 8'h0F) begin
            errors++;
            $display("FAIL single_beat: got valid=%b tlast=%b tkeep=%h, required 1 1 0f",
                     m_if.tvalid, m_if.tlast, m_if.tkeep);
        end
        wait_drain();
        check_cnt("single_len", tx_packet_len, 32'd1);
        check_cnt("single_sop", tx_sop_cnt, 32'd2);
        check_cnt("single_eop", tx_eop_cnt, 32'd2);
    endtask

    task automatic test_back_to_back();
        int low_run;
        int max_low;
        low_run = 0;
        max_low = 0;
        m_if.tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push_beat({$urandom, $urandom}, 8'hFF, i[3:0], (i % 4) == 0, (i % 4) == 3);
                idle_in();
            end
            begin
                repeat (24) begin
                    @(posedge clk);
                    #1;
                    m_if.tready = ~m_if.tready;
                end
                m_if.tready = 1'b1;
            end
            begin
                repeat (24) begin
                    @(negedge clk);
                    low_run = s_if.tready ? 0 : low_run + 1;
                    if (low_run > max_low) max_low = low_run;
                end
            end
        join
        checks++;
        if (max_low > 1) begin
            errors++;
            $display("FAIL toggle_tready_low: got %0d cycles, required at most 1", max_low);
        end
        wait_drain();
        check_cnt("toggle_len", tx_packet_len, 32'd4);
        check_cnt("toggle_sop", tx_sop_cnt, 32'd4);
        check_cnt("toggle_eop", tx_eop_cnt, 32'd4);
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] held;
        int unstable;
        unstable = 0;
        m_if.tready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push_beat({32'hA5A5_0000 + i, 32'h0102_0304 * (i + 1)}, 8'hFF, 4'h3,
                              i == 0, i == 7);
                idle_in();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                m_if.tready = 1'b0;
                repeat (4) @(negedge clk);
                held = m_if.tdata;
                checks++;
                if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b1 || sb.size() != 2) begin
                    errors++;
                    $display("FAIL stall_buffered: got tready=%b tvalid=%b buffered=%0d, required 0 1 2",
                             s_if.tready, m_if.tvalid, sb.size());
                end
                repeat (6) begin
                    @(negedge clk);
                    if (m_if.tdata !== held || m_if.tvalid !== 1'b1) unstable++;
                end
                checks++;
                if (unstable != 0) begin
                    errors++;
                    $display("FAIL stall_stable: got %0d unstable cycles, required 0", unstable);
                end
                @(posedge clk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        wait_drain();
        check_cnt("stall_len", tx_packet_len, 32'd8);
        check_cnt("stall_sop", tx_sop_cnt, 32'd5);
        check_cnt("stall_eop", tx_eop_cnt, 32'd5);
    endtask

    task automatic test_frame_check();
`ifdef EGRESS_FRAME_CHECK_EN
        m_if.tready = 1'b1;
        push_beat(64'h1111_2222_3333_4444, 8'hFF, 4'h0, 1'b0, 1'b0);
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        check_cnt("orphan_err", tx_err_cnt, 32'd1);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_forwarded: got tvalid=%b, required 0", m_if.tvalid);
        end
        push_beat(64'h5555_6666_7777_8888, 8'hFF, 4'h2, 1'b1, 1'b0);
        push_beat(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 4'h2, 1'b1, 1'b0);
        push_beat(64'hDDDD_EEEE_FFFF_0000, 8'hFF, 4'h2, 1'b0, 1'b1);
        idle_in();
        wait_drain();
        check_cnt("restart_err", tx_err_cnt, 32'd2);
        check_cnt("restart_len", tx_packet_len, 32'd2);
        check_cnt("restart_sop", tx_sop_cnt, 32'd7);
        check_cnt("restart_eop", tx_eop_cnt, 32'd6);
`else
        check_cnt("err_tied", tx_err_cnt, 32'd0);
`endif
    endtask

    task automatic test_reset_mid();
        m_if.tready = 1'b0;
        push_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 4'h4, 1'b1, 1'b0);
        push_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 4'h4, 1'b0, 1'b0);
        idle_in();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({s_if.tready, m_if.tvalid, m_if.tlast, m_if.tdata} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got tready=%b tvalid=%b data=%h, required 0",
                     s_if.tready, m_if.tvalid, m_if.tdata);
        end
        checks++;
        if ({tx_packet_len, tx_sop_cnt, tx_eop_cnt, tx_err_cnt} !== 128'd0) begin
            errors++;
            $display("FAIL midreset_counters: got len=%0d sop=%0d eop=%0d err=%0d, required 0",
                     tx_packet_len, tx_sop_cnt, tx_eop_cnt, tx_err_cnt);
        end
        m_if.tready = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_beat(64'h0F0E_0D0C_0B0A_0908, 8'hFF, 4'h8, 1'b1, 1'b0);
        push_beat(64'h0706_0504_0302_0100, 8'h3F, 4'h8, 1'b0, 1'b1);
        idle_in();
        wait_drain();
        check_cnt("fresh_len", tx_packet_len, 32'd2);
        check_cnt("fresh_sop", tx_sop_cnt, 32'd1);
        check_cnt("fresh_eop", tx_eop_cnt, 32'd1);
    endtask

    initial begin
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tvalid = 1'b0;
        s_if.sop    = 1'b0;
        s_if.eop    = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_basic();
        test_single();
        test_back_to_back();
        test_stall();
        test_frame_check();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
